// File: rtl/fetch_ctrl.sv
// Fetch controller: gates the fetch PC against a credit budget, issues in-order
// instruction-memory requests, pairs each response with its PC via a tag FIFO,
// buffers fetched instructions toward decode and discards stale responses
// that were in flight when a redirect arrived.
module fetch_ctrl #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [XLEN-1:0] pc,
    output logic            stall_pc,
    output logic            pc_update_control,
    output logic [XLEN-1:0] pc_update_val,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [XLEN-1:0] pc;
    } inst_ent_t;

    state_t          state;
    logic [CW-1:0]   drop_cnt;

    logic [XLEN-1:0] tag_mem [DEPTH];
    logic [AW-1:0]   tag_wp, tag_rp;
    logic [CW-1:0]   tag_cnt;

    inst_ent_t       inst_mem [DEPTH];
    logic [AW-1:0]   inst_wp, inst_rp;
    logic [CW-1:0]   inst_cnt;

    logic            active, is_run, redir, credit_ok;
    logic            req_fire, rsp_take, inst_pop;
    logic [CW-1:0]   drop_base, drop_next;

    // Issue, stall, redirect and decode-side handshakes
    always_comb begin
        active    = (state != IDLE);
        is_run    = (state == RUN);
        redir     = redirect_valid & active;
        // Credit counts only registered occupancy; a pop this cycle frees a
        // slot for next cycle, keeping the request path off the pop path.
        credit_ok = ({1'b0, tag_cnt} + {1'b0, inst_cnt}) < (CW+1)'(DEPTH);

        imem_req_valid    = is_run & credit_ok & ~redirect_valid;
        imem_req_addr     = pc;
        req_fire          = imem_req_valid & imem_req_ready;
        stall_pc          = active ? (~req_fire & ~redirect_valid) : 1'b1;
        pc_update_control = redir;
        pc_update_val     = redir ? redirect_pc : '0;

        // Responses with nothing outstanding cannot be paired and are ignored
        rsp_take   = is_run & imem_rsp_valid & (tag_cnt != '0) & ~redirect_valid;
        inst_valid = (inst_cnt != '0) & ~redirect_valid;
        inst_pop   = inst_valid & inst_ready;
        inst_data  = inst_mem[inst_rp].data;
        inst_pc    = inst_mem[inst_rp].pc;

        // Responses still owed after a redirect; one arriving in the redirect
        // cycle itself is already stale and is consumed here.
        drop_base = (state == DRAIN) ? drop_cnt : tag_cnt;
        drop_next = (imem_rsp_valid && (drop_base != '0)) ? drop_base - CW'(1) : drop_base;
    end

    // Control FSM and stale-response drop counter
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state    <= IDLE;
            drop_cnt <= '0;
        end else begin
            case (state)
                IDLE: state <= RUN;
                RUN: begin
                    if (redirect_valid) begin
                        drop_cnt <= drop_next;
                        state    <= (drop_next != '0) ? DRAIN : RUN;
                    end
                end
                DRAIN: begin
                    if (redirect_valid) begin
                        drop_cnt <= drop_next;
                        state    <= (drop_next != '0) ? DRAIN : RUN;
                    end else if (imem_rsp_valid && (drop_cnt != '0)) begin
                        drop_cnt <= drop_cnt - CW'(1);
                        if (drop_cnt == CW'(1)) state <= RUN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag FIFO pointers: PCs of requests awaiting a response
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            tag_wp  <= '0;
            tag_rp  <= '0;
            tag_cnt <= '0;
        end else if (redir) begin
            tag_wp  <= '0;
            tag_rp  <= '0;
            tag_cnt <= '0;
        end else begin
            if (req_fire) tag_wp <= tag_wp + AW'(1);
            if (rsp_take) tag_rp <= tag_rp + AW'(1);
            tag_cnt <= tag_cnt + CW'(req_fire) - CW'(rsp_take);
        end
    end

    // Instruction FIFO pointers: fetched words waiting for decode
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            inst_wp  <= '0;
            inst_rp  <= '0;
            inst_cnt <= '0;
        end else if (redir) begin
            inst_wp  <= '0;
            inst_rp  <= '0;
            inst_cnt <= '0;
        end else begin
            if (rsp_take) inst_wp <= inst_wp + AW'(1);
            if (inst_pop) inst_rp <= inst_rp + AW'(1);
            inst_cnt <= inst_cnt + CW'(rsp_take) - CW'(inst_pop);
        end
    end

    // FIFO storage; occupancy is tracked by the pointer blocks, so no reset
    always_ff @(posedge i_clk) begin
        if (req_fire) tag_mem[tag_wp] <= pc;
        if (rsp_take) inst_mem[inst_wp] <= '{data: imem_rsp_data, pc: tag_mem[tag_rp]};
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: fetch-unit PC model, in-order memory model and a
// decode-stream reference (contiguous PCs from the last redirect target).
module tb_fetch_ctrl;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic            i_clk = 1'b0;
    logic            i_rst = 1'b0;
    logic [XLEN-1:0] pc;
    logic            stall_pc, pc_update_control, imem_req_valid, imem_req_ready;
    logic [XLEN-1:0] pc_update_val, imem_req_addr, imem_rsp_data, redirect_pc;
    logic            imem_rsp_valid, redirect_valid, inst_valid, inst_ready;
    logic [XLEN-1:0] inst_data, inst_pc;

    fetch_ctrl #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .pc(pc), .stall_pc(stall_pc),
        .pc_update_control(pc_update_control), .pc_update_val(pc_update_val),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc)
    );

    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } mreq_t;

    mreq_t       mq[$];
    int          cyc = 0;
    int          buffered = 0;
    int          mem_lat = 1;
    bit          rand_lat = 0;
    bit          rsp_rand = 0;
    int          rdy_mode = 0;
    logic [31:0] exp_pc = 0;
    logic [31:0] obs_pc[$];
    logic [31:0] obs_data[$];
    logic [31:0] exp_q[$];
    bit          s_fire, s_stall, s_pcu, s_acc, s_redir, s_rsp;
    logic [31:0] s_pcv;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
    endfunction

    // Environment: sample mid-cycle, advance models just after the edge
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_req_ready = 1'b1;
        pc             = '0;
        forever begin
            @(negedge i_clk);
            s_fire  = imem_req_valid & imem_req_ready;
            s_stall = stall_pc;
            s_pcu   = pc_update_control;
            s_pcv   = pc_update_val;
            s_acc   = inst_valid & inst_ready;
            s_redir = redirect_valid & i_rst;
            s_rsp   = imem_rsp_valid;
            if (!i_rst) exp_pc = '0;
            else begin
                if (s_acc) begin
                    obs_pc.push_back(inst_pc);
                    obs_data.push_back(inst_data);
                    exp_q.push_back(exp_pc);
                    exp_pc = exp_pc + 32'd4;
                end
                if (s_redir) exp_pc = redirect_pc;
            end
            @(posedge i_clk);
            #1;
            cyc++;
            if (!i_rst) begin
                mq.delete();
                buffered       = 0;
                pc             = '0;
                imem_rsp_valid = 1'b0;
            end else begin
                if (s_redir) begin
                    foreach (mq[i]) mq[i].stale = 1'b1;
                    buffered = 0;
                end
                if (s_rsp && mq.size() > 0) begin
                    if (!mq[0].stale) buffered++;
                    void'(mq.pop_front());
                end
                if (s_acc) buffered--;
                if (s_fire) mq.push_back('{addr: pc,
                    due: cyc - 1 + (rand_lat ? int'($urandom_range(1, 4)) : mem_lat), stale: 1'b0});
                if (s_pcu) pc = s_pcv;
                else if (!s_stall) pc = pc + 32'd4;
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = $urandom;
                if (mq.size() > 0) begin
                    if (mq[0].due <= cyc && (!rsp_rand || $urandom_range(0, 2) != 0)) begin
                        imem_rsp_valid = 1'b1;
                        imem_rsp_data  = mem_word(mq[0].addr);
                    end
                end
            end
            imem_req_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    task automatic step();
        @(posedge i_clk);
        #2;
    endtask

    // Leaves the caller at the first (IDLE) cycle after release
    task automatic do_reset();
        step();
        redirect_valid = 1'b0;
        i_rst = 1'b0;
        rdy_mode = 0; rsp_rand = 0; rand_lat = 0; mem_lat = 1;
        step();
        step();
        i_rst = 1'b1;
    endtask

    task automatic test_reset();
        redirect_valid = 1'b0;
        redirect_pc    = 32'h1234;
        inst_ready     = 1'b1;
        @(negedge i_clk);
        checks++; if (stall_pc !== 1'b1) begin errors++; $display("FAIL rst_stall: got %b want 1", stall_pc); end
        checks++; if (pc_update_control !== 1'b0) begin errors++; $display("FAIL rst_pcu: got %b want 0", pc_update_control); end
        checks++; if (pc_update_val !== 32'h0) begin errors++; $display("FAIL rst_pcv: got %h want 0", pc_update_val); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", imem_req_valid); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_inst: got %b want 0", inst_valid); end
        step();
        i_rst = 1'b1;
        @(negedge i_clk);
        checks++; if (stall_pc !== 1'b1 || imem_req_valid !== 1'b0) begin
            errors++; $display("FAIL idle_cycle: stall=%b req=%b want 1/0", stall_pc, imem_req_valid); end
    endtask

    task automatic test_stream();
        logic [31:0] e;
        do_reset();
        inst_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge i_clk);
            checks++; if (stall_pc !== (c == 0)) begin
                errors++; $display("FAIL stream_stall c=%0d: got %b want %b", c, stall_pc, (c == 0)); end
            if (c >= 3) begin
                e = 32'(4 * (c - 3));
                checks++; if (inst_valid !== 1'b1 || inst_pc !== e || inst_data !== mem_word(e)) begin
                    errors++; $display("FAIL stream_inst c=%0d: got v=%b pc=%h d=%h want 1 %h %h",
                        c, inst_valid, inst_pc, inst_data, e, mem_word(e)); end
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        int fires;
        do_reset();
        inst_ready = 1'b0;
        fires = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge i_clk);
            if (imem_req_valid && imem_req_ready) fires++;
            step();
        end
        checks++; if (fires !== DEPTH) begin errors++; $display("FAIL bp_fires: got %0d want %0d", fires, DEPTH); end
        @(negedge i_clk);
        checks++; if (stall_pc !== 1'b1 || imem_req_valid !== 1'b0) begin
            errors++; $display("FAIL bp_full: stall=%b req=%b want 1/0", stall_pc, imem_req_valid); end
        step();
        inst_ready = 1'b1;
        @(negedge i_clk);
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
            errors++; $display("FAIL bp_pop: v=%b pc=%h want 1 0", inst_valid, inst_pc); end
        step();
        inst_ready = 1'b0;
        fires = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge i_clk);
            if (imem_req_valid && imem_req_ready) fires++;
            step();
        end
        checks++; if (fires !== 1) begin errors++; $display("FAIL bp_one_more: got %0d want 1", fires); end
    endtask

    task automatic test_req_stall();
        int st;
        bit found;
        do_reset();
        inst_ready = 1'b1;
        st = obs_pc.size();
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge i_clk);
            if (pc == 32'hC && imem_req_valid && imem_req_ready) found = 1;
            else step();
        end
        checks++; if (!found) begin errors++; $display("FAIL rs_reach: pc 0xC not accepted, got pc=%h", pc); end
        rdy_mode = 2;
        for (int c = 0; c < 3; c++) begin
            step();
            @(negedge i_clk);
            checks++; if (stall_pc !== 1'b1 || imem_req_addr !== 32'h10) begin
                errors++; $display("FAIL rs_hold c=%0d: stall=%b addr=%h want 1 10", c, stall_pc, imem_req_addr); end
        end
        rdy_mode = 0;
        for (int c = 0; c < 20; c++) step();
        checks++; if (obs_pc.size() - st < 12) begin errors++; $display("FAIL rs_count: got %0d want >=12", obs_pc.size() - st); end
        for (int i = st; i < obs_pc.size(); i++) begin
            checks++; if (obs_pc[i] !== 32'(4 * (i - st))) begin
                errors++; $display("FAIL rs_seq i=%0d: got %h want %h", i - st, obs_pc[i], 32'(4 * (i - st))); end
        end
    endtask

    task automatic test_redirect();
        int st;
        bit found;
        do_reset();
        inst_ready = 1'b1;
        mem_lat = 2;
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            step();
            if (c >= 3 && mq.size() == 2 && imem_rsp_valid) found = 1;
        end
        checks++; if (!found) begin errors++; $display("FAIL rd_setup: outstanding=%0d rsp=%b want 2 1", mq.size(), imem_rsp_valid); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        st = obs_pc.size();
        @(negedge i_clk);
        checks++; if (pc_update_control !== 1'b1 || pc_update_val !== 32'h200) begin
            errors++; $display("FAIL rd_update: pcu=%b pcv=%h want 1 200", pc_update_control, pc_update_val); end
        checks++; if (stall_pc !== 1'b0 || imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            errors++; $display("FAIL rd_cycle: stall=%b req=%b inst=%b want 0 0 0", stall_pc, imem_req_valid, inst_valid); end
        step();
        redirect_valid = 1'b0;
        @(negedge i_clk);
        checks++; if (stall_pc !== 1'b1 || imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            errors++; $display("FAIL rd_drain: stall=%b req=%b inst=%b want 1 0 0", stall_pc, imem_req_valid, inst_valid); end
        step();
        @(negedge i_clk);
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
            errors++; $display("FAIL rd_first_req: req=%b addr=%h want 1 200", imem_req_valid, imem_req_addr); end
        for (int c = 0; c < 15; c++) step();
        checks++; if (obs_pc.size() - st < 8) begin errors++; $display("FAIL rd_count: got %0d want >=8", obs_pc.size() - st); end
        for (int i = st; i < obs_pc.size(); i++) begin
            checks++; if (obs_pc[i] !== 32'h200 + 32'(4 * (i - st)) || obs_data[i] !== mem_word(obs_pc[i])) begin
                errors++; $display("FAIL rd_seq i=%0d: got pc=%h d=%h want pc=%h", i - st, obs_pc[i], obs_data[i],
                    32'h200 + 32'(4 * (i - st))); end
        end
    endtask

    task automatic test_back_to_back();
        int st;
        bit found;
        do_reset();
        inst_ready = 1'b1;
        mem_lat = 3;
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            step();
            if (c >= 3 && mq.size() == 3 && imem_rsp_valid) found = 1;
        end
        checks++; if (!found) begin errors++; $display("FAIL b2b_setup: outstanding=%0d want 3", mq.size()); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        @(negedge i_clk);
        checks++; if (pc_update_val !== 32'h100) begin errors++; $display("FAIL b2b_first: pcv=%h want 100", pc_update_val); end
        step();
        redirect_pc = 32'h300;
        st = obs_pc.size();
        @(negedge i_clk);
        checks++; if (pc_update_control !== 1'b1 || pc_update_val !== 32'h300 || inst_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_second: pcu=%b pcv=%h inst=%b want 1 300 0", pc_update_control, pc_update_val, inst_valid); end
        step();
        redirect_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge i_clk);
            if (inst_valid) begin
                checks++; if ((inst_pc & ~32'hFF) !== 32'h300) begin
                    errors++; $display("FAIL b2b_stale c=%0d: got pc=%h want 3xx", c, inst_pc); end
            end
            step();
        end
        checks++; if (obs_pc.size() - st < 5) begin errors++; $display("FAIL b2b_count: got %0d want >=5", obs_pc.size() - st); end
        else begin
            checks++; if (obs_pc[st] !== 32'h300) begin errors++; $display("FAIL b2b_head: got %h want 300", obs_pc[st]); end
        end
    endtask

    task automatic test_random();
        int st;
        logic [31:0] r;
        do_reset();
        rdy_mode = 1; rsp_rand = 1; rand_lat = 1;
        st = obs_pc.size();
        for (int c = 0; c < 3000; c++) begin
            r = $urandom;
            inst_ready     = ($urandom_range(0, 3) != 0);
            redirect_valid = (c > 3) && ($urandom_range(0, 19) == 0);
            redirect_pc    = {16'h0, r[13:0], 2'b00};
            @(negedge i_clk);
            if (redirect_valid) begin
                checks++; if (pc_update_control !== 1'b1 || pc_update_val !== redirect_pc || stall_pc !== 1'b0 ||
                              imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
                    errors++; $display("FAIL rnd_redir c=%0d: pcu=%b pcv=%h stall=%b req=%b inst=%b want 1 %h 0 0 0",
                        c, pc_update_control, pc_update_val, stall_pc, imem_req_valid, inst_valid, redirect_pc); end
            end else begin
                checks++; if (pc_update_control !== 1'b0 || pc_update_val !== 32'h0) begin
                    errors++; $display("FAIL rnd_noredir c=%0d: pcu=%b pcv=%h want 0 0", c, pc_update_control, pc_update_val); end
            end
            if (imem_req_valid && imem_req_ready) begin
                checks++; if (mq.size() + buffered >= DEPTH || imem_req_addr !== pc) begin
                    errors++; $display("FAIL rnd_credit c=%0d: occ=%0d addr=%h want occ<%0d addr=%h",
                        c, mq.size() + buffered, imem_req_addr, DEPTH, pc); end
            end
            step();
        end
        redirect_valid = 1'b0;
        checks++; if (obs_pc.size() - st < 300) begin errors++; $display("FAIL rnd_progress: got %0d want >=300", obs_pc.size() - st); end
        for (int i = st; i < obs_pc.size(); i++) begin
            checks++; if (obs_pc[i] !== exp_q[i] || obs_data[i] !== mem_word(exp_q[i])) begin
                errors++; $display("FAIL rnd_stream i=%0d: got pc=%h d=%h want pc=%h d=%h",
                    i - st, obs_pc[i], obs_data[i], exp_q[i], mem_word(exp_q[i])); end
        end
    endtask

    task automatic test_mid_reset();
        int st;
        do_reset();
        inst_ready = 1'b0;
        for (int c = 0; c < 4; c++) step();
        @(negedge i_clk);
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL mr_prefill: inst=%b want 1", inst_valid); end
        step();
        i_rst = 1'b0;
        #1;
        checks++; if (stall_pc !== 1'b1 || pc_update_control !== 1'b0 || pc_update_val !== 32'h0 ||
                      imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            errors++; $display("FAIL mr_outputs: stall=%b pcu=%b pcv=%h req=%b inst=%b want 1 0 0 0 0",
                stall_pc, pc_update_control, pc_update_val, imem_req_valid, inst_valid); end
        step();
        step();
        i_rst = 1'b1;
        inst_ready = 1'b1;
        st = obs_pc.size();
        @(negedge i_clk);
        checks++; if (stall_pc !== 1'b1 || inst_valid !== 1'b0) begin
            errors++; $display("FAIL mr_idle: stall=%b inst=%b want 1 0", stall_pc, inst_valid); end
        for (int c = 0; c < 20; c++) step();
        checks++; if (obs_pc.size() - st < 12) begin errors++; $display("FAIL mr_count: got %0d want >=12", obs_pc.size() - st); end
        for (int i = st; i < obs_pc.size(); i++) begin
            checks++; if (obs_pc[i] !== 32'(4 * (i - st)) || obs_data[i] !== mem_word(32'(4 * (i - st)))) begin
                errors++; $display("FAIL mr_seq i=%0d: got pc=%h d=%h want pc=%h", i - st, obs_pc[i], obs_data[i],
                    32'(4 * (i - st))); end
        end
    endtask

    initial begin
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b1;
        test_reset();
        test_stream();
        test_backpressure();
        test_req_stall();
        test_redirect();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
